// File: rtl/sort_result_checker.sv
// Result checker behind the serial sorter: verifies signed non-decreasing order per frame
// and captures min, max, median and sum, presenting them with a level done flag.
module sort_result_checker #(
    parameter int N     = 10,
    parameter int WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [WIDTH-1:0]           data_serial_i,
    input  logic                              data_valid_i,
    input  logic                              clear_i,
    output logic [$clog2(N+1)-1:0]            count_o,
    output logic signed [WIDTH-1:0]           min_o,
    output logic signed [WIDTH-1:0]           max_o,
    output logic signed [WIDTH-1:0]           median_o,
    output logic signed [WIDTH+$clog2(N)-1:0] sum_o,
    output logic                              done_o,
    output logic                              order_err_o,
    output logic [$clog2(N)-1:0]              err_idx_o
);

    localparam int CW  = $clog2(N+1);
    localparam int IW  = $clog2(N);
    localparam int SW  = WIDTH + IW;
    localparam int MID = (N-1)/2;
    localparam logic [CW-1:0] MID_C  = CW'(MID);
    localparam logic [CW-1:0] LAST_C = CW'(N-1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            count_q, count_d;
    logic signed [WIDTH-1:0]  min_q, min_d;
    logic signed [WIDTH-1:0]  max_q, max_d;
    logic signed [WIDTH-1:0]  median_q, median_d;
    logic signed [WIDTH-1:0]  prev_q, prev_d;
    logic signed [SW-1:0]     sum_q, sum_d;
    logic                     done_q, done_d;
    logic                     order_err_q, order_err_d;
    logic [IW-1:0]            err_idx_q, err_idx_d;
    logic signed [SW-1:0]     word_ext;

    assign word_ext = {{IW{data_serial_i[WIDTH-1]}}, data_serial_i};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            min_q       <= '0;
            max_q       <= '0;
            median_q    <= '0;
            prev_q      <= '0;
            sum_q       <= '0;
            done_q      <= 1'b0;
            order_err_q <= 1'b0;
            err_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            min_q       <= min_d;
            max_q       <= max_d;
            median_q    <= median_d;
            prev_q      <= prev_d;
            sum_q       <= sum_d;
            done_q      <= done_d;
            order_err_q <= order_err_d;
            err_idx_q   <= err_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        min_d       = min_q;
        max_d       = max_q;
        median_d    = median_q;
        prev_d      = prev_q;
        sum_d       = sum_q;
        done_d      = done_q;
        order_err_d = order_err_q;
        err_idx_d   = err_idx_q;

        if (clear_i) begin
            state_d     = IDLE;
            count_d     = '0;
            min_d       = '0;
            max_d       = '0;
            median_d    = '0;
            prev_d      = '0;
            sum_d       = '0;
            done_d      = 1'b0;
            order_err_d = 1'b0;
            err_idx_d   = '0;
        end else begin
            unique case (state_q)
                // A new frame may start from IDLE or straight out of DONE.
                IDLE, DONE: begin
                    if (data_valid_i) begin
                        state_d     = COLLECT;
                        count_d     = CW'(1);
                        min_d       = data_serial_i;
                        max_d       = data_serial_i;
                        prev_d      = data_serial_i;
                        sum_d       = word_ext;
                        median_d    = (MID == 0) ? data_serial_i : '0;
                        done_d      = 1'b0;
                        order_err_d = 1'b0;
                        err_idx_d   = '0;
                    end
                end
                COLLECT: begin
                    if (data_valid_i) begin
                        sum_d   = sum_q + word_ext;
                        count_d = count_q + CW'(1);
                        prev_d  = data_serial_i;
                        if (data_serial_i < min_q) min_d = data_serial_i;
                        if (data_serial_i > max_q) max_d = data_serial_i;
                        if (count_q == MID_C) median_d = data_serial_i;
                        // Only the first out-of-order position is recorded.
                        if ((data_serial_i < prev_q) && !order_err_q) begin
                            order_err_d = 1'b1;
                            err_idx_d   = IW'(count_q);
                        end
                        if (count_q == LAST_C) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign count_o     = count_q;
    assign min_o       = min_q;
    assign max_o       = max_q;
    assign median_o    = median_q;
    assign sum_o       = sum_q;
    assign done_o      = done_q;
    assign order_err_o = order_err_q;
    assign err_idx_o   = err_idx_q;

endmodule

// File: tb/tb_sort_result_checker.sv
// Self-checking bench for sort_result_checker: directed frames with a result scoreboard.
module tb_sort_result_checker;

    localparam int N     = 10;
    localparam int WIDTH = 32;
    localparam int SW    = WIDTH + $clog2(N);

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic signed [WIDTH-1:0]      data_serial_i = '0;
    logic                         data_valid_i = 1'b0;
    logic                         clear_i = 1'b0;
    logic [$clog2(N+1)-1:0]       count_o;
    logic signed [WIDTH-1:0]      min_o;
    logic signed [WIDTH-1:0]      max_o;
    logic signed [WIDTH-1:0]      median_o;
    logic signed [SW-1:0]         sum_o;
    logic                         done_o;
    logic                         order_err_o;
    logic [$clog2(N)-1:0]         err_idx_o;

    typedef struct {
        longint minV;
        longint maxV;
        longint medV;
        longint sumV;
        longint err;
        longint idx;
    } expect_t;

    expect_t                 sb[$];
    logic signed [WIDTH-1:0] frame [N];
    int                      testCount = 0;
    int                      failCount = 0;

    sort_result_checker #(.N(N), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .data_serial_i (data_serial_i),
        .data_valid_i  (data_valid_i),
        .clear_i       (clear_i),
        .count_o       (count_o),
        .min_o         (min_o),
        .max_o         (max_o),
        .median_o      (median_o),
        .sum_o         (sum_o),
        .done_o        (done_o),
        .order_err_o   (order_err_o),
        .err_idx_o     (err_idx_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of input; returns 1ns after the sampling edge.
    task automatic applyStimulus(input logic signed [WIDTH-1:0] w, input logic v);
        data_serial_i = w;
        data_valid_i  = v;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_count"},  64'(count_o),     0);
        checkOutput({tag, "_min"},    64'(min_o),       0);
        checkOutput({tag, "_max"},    64'(max_o),       0);
        checkOutput({tag, "_median"}, 64'(median_o),    0);
        checkOutput({tag, "_sum"},    64'(sum_o),       0);
        checkOutput({tag, "_done"},   64'(done_o),      0);
        checkOutput({tag, "_err"},    64'(order_err_o), 0);
        checkOutput({tag, "_idx"},    64'(err_idx_o),   0);
    endtask

    task automatic pushExpected();
        expect_t e;
        e.minV = frame[0];
        e.maxV = frame[0];
        e.sumV = 0;
        e.err  = 0;
        e.idx  = 0;
        e.medV = frame[(N-1)/2];
        for (int i = 0; i < N; i++) begin
            e.sumV += longint'(frame[i]);
            if (longint'(frame[i]) < e.minV) e.minV = frame[i];
            if (longint'(frame[i]) > e.maxV) e.maxV = frame[i];
            if (e.err == 0 && i > 0 && frame[i] < frame[i-1]) begin
                e.err = 1;
                e.idx = i;
            end
        end
        sb.push_back(e);
    endtask

    task automatic checkResults();
        int      waitCycles;
        expect_t e;
        waitCycles = 0;
        while (done_o !== 1'b1 && waitCycles < 8) begin
            applyStimulus('0, 1'b0);
            waitCycles++;
        end
        checkOutput("done_latency", 64'(waitCycles), 0);
        checkOutput("done",         64'(done_o),     1);
        checkOutput("sb_size",      64'(sb.size()),  1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("min",     64'(min_o),       e.minV);
            checkOutput("max",     64'(max_o),       e.maxV);
            checkOutput("median",  64'(median_o),    e.medV);
            checkOutput("sum",     64'(sum_o),       e.sumV);
            checkOutput("err",     64'(order_err_o), e.err);
            checkOutput("err_idx", 64'(err_idx_o),   e.err != 0 ? e.idx : 0);
            checkOutput("count",   64'(count_o),     N);
        end
    endtask

    task automatic sendFrame(input int maxGap);
        int g;
        bit runErr;
        runErr = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (maxGap > 0 && i > 0) begin
                g = $urandom_range(maxGap, 0);
                for (int k = 0; k < g; k++) begin
                    applyStimulus($urandom, 1'b0);
                    checkOutput("gap_count", 64'(count_o), i);
                    checkOutput("gap_done",  64'(done_o),  0);
                end
            end
            if (i > 0 && frame[i] < frame[i-1]) runErr = 1'b1;
            if (i == N-1) pushExpected();
            applyStimulus(frame[i], 1'b1);
            if (i < N-1) begin
                checkOutput("run_done",  64'(done_o),      0);
                checkOutput("run_count", 64'(count_o),     i+1);
                checkOutput("run_err",   64'(order_err_o), runErr);
            end
        end
        data_valid_i = 1'b0;
        checkResults();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkAllZero("reset");
        rst = 1'b1;

        // Sorted frame, one word per cycle.
        frame = '{-881, -750, -347, -281, 0, 203, 345, 383, 570, 797};
        sendFrame(0);

        // Positions 6 and 7 swapped, started back-to-back with the previous frame.
        frame = '{-881, -750, -347, -281, 0, 203, 383, 345, 570, 797};
        sendFrame(0);
        applyStimulus('0, 1'b0);
        applyStimulus('0, 1'b0);
        checkOutput("hold_done", 64'(done_o), 1);
        checkOutput("hold_min",  64'(min_o),  -881);
        checkOutput("hold_idx",  64'(err_idx_o), 7);

        // Most negative words with random valid gaps.
        for (int i = 0; i < N; i++) frame[i] = 32'sh80000000;
        sendFrame(3);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) applyStimulus(100 + i, 1'b1);
        data_valid_i = 1'b0;
        checkOutput("pre_rst_count", 64'(count_o), 5);
        #2 rst = 1'b0;
        #1 checkAllZero("rst_mid");
        @(posedge clk);
        #1 checkAllZero("rst_hold");
        #3 rst = 1'b1;
        for (int i = 0; i < N; i++) frame[i] = i + 1;
        sendFrame(0);

        // Clear coincident with the third word of a frame.
        applyStimulus(11, 1'b1);
        applyStimulus(12, 1'b1);
        checkOutput("pre_clr_count", 64'(count_o), 2);
        clear_i = 1'b1;
        applyStimulus(13, 1'b1);
        clear_i = 1'b0;
        data_valid_i = 1'b0;
        checkAllZero("clear");
        frame = '{5, -3, 7, 7, 9, -100, 12, 20, 20, 30};
        sendFrame(0);

        // Sorted frame straight after an erroneous one: no error carry-over.
        frame = '{-40, -30, -30, -1, 2, 2, 8, 1000, 2147483647, 2147483647};
        sendFrame(0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
